tmds_gearbox: RTL and testbench
===============================

# tmds_gearbox

Parametrised multi-channel soft gearbox that converts kParallelWidth-bit encoded TMDS words into kOutWidth-bit lane chunks, LSB-first, on a single clock. It replaces fixed-ratio 10:1 primitive cascades with a ratio-agnostic, back-pressured stage between the TMDS encoders and a narrow output primitive or transceiver. It adds lockstep channels, a training-pattern mode, bit-slip alignment and underrun detection.

## Interface
- kParallelWidth, 10: encoded word width per channel.
- kOutWidth, 4: chunk width per channel per cycle; 1 ≤ kOutWidth ≤ kParallelWidth.
- kChannels, 3: number of lockstep lanes.
- kTrainWord, 10'b1101010100: substituted word in training mode; width kParallelWidth.
- PixelClk  in  1  sole clock; all state on rising edge.
- aRst  in  1  asynchronous, active-high reset.
- pData  in  kChannels*kParallelWidth  channel c at bits [c*kParallelWidth +: kParallelWidth].
- pValid  in  1  input word valid.
- pReady  out  1  gearbox accepts a word this cycle.
- pTrain  in  1  sampled with each accepted word; 1 substitutes kTrainWord on all channels.
- sData  out  kChannels*kOutWidth  channel c at [c*kOutWidth +: kOutWidth]; bit 0 transmitted first.
- sValid  out  1  chunk valid.
- sReady  in  1  downstream consumes chunk.
- sSlip  in  1  one-cycle pulse: discard one bit from every lane.
- sUnderrun  out  1  sticky underrun flag.

## Operation
- Per-lane shift buffer, capacity kParallelWidth+2*kOutWidth-1 bits; a shared fill counter, width $clog2(capacity+1), tracks valid bits in all lanes.
- Accept = pValid && pReady. Emit = sValid && sReady. Slip = slipPending && fill ≥ (Emit ? kOutWidth : 0)+1.
- pReady = (fill < 2*kOutWidth) && !aRst. It has no combinational dependency on sReady or pValid.
- sValid = (fill ≥ kOutWidth). sData = lowest kOutWidth bits of each lane buffer, driven straight from registers.
- Update order within one cycle:
  - On Emit, shift right by kOutWidth.
  - On Slip, shift right by 1 more.
  - On Accept, write the word at bit offset fill−(Emit?kOutWidth:0)−(Slip?1:0).
  - fill_next = fill + Accept*kParallelWidth − Emit*kOutWidth − Slip.
- LSB-first: word bit 0 leaves before bit kParallelWidth−1. Chunk order is oldest first.
- slipPending: set on sSlip, cleared on the cycle Slip applies. Pulses arriving while pending coalesce into one slip.
- sUnderrun: set when sReady && !sValid occurs after the first accepted word since reset. Cleared only by aRst.
- Training: an accepted word with pTrain=1 loads kTrainWord into every lane, ignoring pData.

## Timing
- Reset values, immediate and asynchronous:
  - fill=0 and buffers=0.
  - sValid=0, sData=0, sUnderrun=0, slipPending=0.
  - pReady=0 while aRst is high; 1 on the first cycle after release.
- Latency: a word accepted at edge N is visible on sData after edge N (cycle N+1) if fill then reaches ≥ kOutWidth.
- Throughput: with pValid held high and sReady=1, sValid never drops after the first accept. Average input rate is kOutWidth/kParallelWidth words per cycle.
- Simultaneous Accept+Emit+Slip is legal; fill never exceeds capacity.
- sReady=0: buffer and fill hold, except for a pending Slip. No data is lost.
- aRst mid-stream discards all buffered bits and any pending slip.

## Structure
- Shared package rgb2dvi_pkg holds:
  - TMDS control tokens, including kTrainWord defaults CTL0..CTL3.
  - The capacity/fill-width helper function.
- Sub-module tmds_gearbox_lane: one lane's shift buffer and insert logic, instantiated kChannels times.
- The top level holds the fill counter, handshake, slip, train and underrun logic.

## Test plan
Defaults apply: kParallelWidth=10, kOutWidth=4, kChannels=3.
- Reset: assert aRst mid-stream → sValid=0, sData=0, sUnderrun=0 at once; pReady=1 one cycle after release.
- Single word: ch0 = 10'b1101010100, sReady=1 → chunks 4'b0100 then 4'b0101. fill=2 remains, sValid=0, and sUnderrun sets on the next cycle.
- Continuous stream: 10 words 0..9, pValid and sReady held at 1 → 25 chunks with no sValid bubble. The reassembled LSB-first bitstream equals the input words concatenated.
- Backpressure: sReady=0 for 10 cycles mid-stream → fill stays at ≤17 and pReady=0 once fill ≥ 8. Output resumes bit-exact.
- Slip: two sSlip pulses one cycle apart during a stream of 0x3FF/0x000 → exactly one bit dropped. The output stream is shifted by one bit on all 3 lanes.
- Train: pTrain=1 with pData = all ones → every lane emits kTrainWord chunks 0100, 0101, … ; pTrain=0 restores pData.

Source files
------------

// File: rtl/rgb2dvi_pkg.sv
// rtl/rgb2dvi_pkg.sv - TMDS control tokens and gearbox sizing helpers
package rgb2dvi_pkg;

  localparam logic [9:0] kCtl0 = 10'b1101010100;
  localparam logic [9:0] kCtl1 = 10'b0010101011;
  localparam logic [9:0] kCtl2 = 10'b0101010100;
  localparam logic [9:0] kCtl3 = 10'b1010101011;

  // Worst case holds a full word on top of up to 2*out-1 leftover bits.
  function automatic int gearbox_capacity(input int par_width, input int out_width);
    return par_width + 2 * out_width - 1;
  endfunction

  function automatic int gearbox_fill_width(input int par_width, input int out_width);
    return $clog2(gearbox_capacity(par_width, out_width) + 1);
  endfunction

endpackage

// File: rtl/tmds_gearbox_lane.sv
// rtl/tmds_gearbox_lane.sv - one lane's LSB-first shift buffer with word insert
module tmds_gearbox_lane
  import rgb2dvi_pkg::*;
#(
  parameter int kParallelWidth = 10,
  parameter int kOutWidth      = 4,
  parameter int kFillWidth     = gearbox_fill_width(kParallelWidth, kOutWidth)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      emit,
  input  logic                      slip,
  input  logic                      load,
  input  logic [kFillWidth-1:0]     offset,
  input  logic [kParallelWidth-1:0] word,
  output logic [kOutWidth-1:0]      chunk
);

  localparam int kCapacity = gearbox_capacity(kParallelWidth, kOutWidth);

  logic [kCapacity-1:0] buffer;
  logic [kCapacity-1:0] shifted;
  logic [kCapacity-1:0] placed;
  logic [kCapacity-1:0] buffer_next;

  // Bits above fill are always zero, so the new word can simply be OR-ed in.
  always_comb begin
    shifted = buffer;
    if (emit) shifted = shifted >> kOutWidth;
    if (slip) shifted = shifted >> 1;
    placed      = {{(kCapacity - kParallelWidth){1'b0}}, word} << offset;
    buffer_next = load ? (shifted | placed) : shifted;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) buffer <= '0;
    else     buffer <= buffer_next;
  end

  assign chunk = buffer[kOutWidth-1:0];

endmodule

// File: rtl/tmds_gearbox.sv
// rtl/tmds_gearbox.sv - multi-lane TMDS word-to-chunk gearbox with slip, train and underrun
module tmds_gearbox
  import rgb2dvi_pkg::*;
#(
  parameter int kParallelWidth = 10,
  parameter int kOutWidth      = 4,
  parameter int kChannels      = 3,
  parameter logic [kParallelWidth-1:0] kTrainWord = kParallelWidth'(kCtl0)
) (
  input  logic                                PixelClk,
  input  logic                                aRst,
  input  logic [kChannels*kParallelWidth-1:0] pData,
  input  logic                                pValid,
  output logic                                pReady,
  input  logic                                pTrain,
  output logic [kChannels*kOutWidth-1:0]      sData,
  output logic                                sValid,
  input  logic                                sReady,
  input  logic                                sSlip,
  output logic                                sUnderrun
);

  localparam int kFillWidth = gearbox_fill_width(kParallelWidth, kOutWidth);
  localparam logic [kFillWidth-1:0] kOutFill    = kFillWidth'(kOutWidth);
  localparam logic [kFillWidth-1:0] kParFill    = kFillWidth'(kParallelWidth);
  localparam logic [kFillWidth-1:0] kReadyLimit = kFillWidth'(2 * kOutWidth);
  localparam logic [kFillWidth-1:0] kOne        = kFillWidth'(1);

  logic [kFillWidth-1:0] fill;
  logic [kFillWidth-1:0] fill_next;
  logic [kFillWidth-1:0] emit_bits;
  logic [kFillWidth-1:0] slip_bits;
  logic [kFillWidth-1:0] insert_offset;
  logic                  accept;
  logic                  emit;
  logic                  slip;
  logic                  slip_pending;
  logic                  started;

  assign pReady = (fill < kReadyLimit) && !aRst;
  assign sValid = (fill >= kOutFill);
  assign accept = pValid && pReady;
  assign emit   = sValid && sReady;
  assign slip   = slip_pending && (fill >= (emit ? kOutFill + kOne : kOne));

  // Insert offset is the fill left after this cycle's emit and slip shifts.
  assign emit_bits     = emit ? kOutFill : '0;
  assign slip_bits     = slip ? kOne : '0;
  assign insert_offset = fill - emit_bits - slip_bits;
  assign fill_next     = insert_offset + (accept ? kParFill : '0);

  always_ff @(posedge PixelClk or posedge aRst) begin
    if (aRst) begin
      fill         <= '0;
      slip_pending <= 1'b0;
      started      <= 1'b0;
      sUnderrun    <= 1'b0;
    end else begin
      fill         <= fill_next;
      slip_pending <= slip_pending ? !slip : sSlip;
      started      <= started | accept;
      sUnderrun    <= sUnderrun | (started && sReady && !sValid);
    end
  end

  for (genvar c = 0; c < kChannels; c++) begin : g_lane
    logic [kParallelWidth-1:0] lane_word;
    assign lane_word = pTrain ? kTrainWord : pData[c*kParallelWidth +: kParallelWidth];

    tmds_gearbox_lane #(
      .kParallelWidth(kParallelWidth),
      .kOutWidth     (kOutWidth),
      .kFillWidth    (kFillWidth)
    ) u_lane (
      .clk   (PixelClk),
      .rst   (aRst),
      .emit  (emit),
      .slip  (slip),
      .load  (accept),
      .offset(insert_offset),
      .word  (lane_word),
      .chunk (sData[c*kOutWidth +: kOutWidth])
    );
  end

endmodule

// File: tb/tb_tmds_gearbox.sv
// tb/tb_tmds_gearbox.sv - scoreboard bench for tmds_gearbox
module tb_tmds_gearbox;

  localparam int P = 10;
  localparam int O = 4;
  localparam int C = 3;
  localparam logic [P-1:0] kTrain = 10'b1101010100;

  logic           PixelClk;
  logic           aRst;
  logic [C*P-1:0] pData;
  logic           pValid;
  logic           pReady;
  logic           pTrain;
  logic [C*O-1:0] sData;
  logic           sValid;
  logic           sReady;
  logic           sSlip;
  logic           sUnderrun;

  tmds_gearbox #(
    .kParallelWidth(P),
    .kOutWidth     (O),
    .kChannels     (C),
    .kTrainWord    (kTrain)
  ) dut (
    .PixelClk (PixelClk),
    .aRst     (aRst),
    .pData    (pData),
    .pValid   (pValid),
    .pReady   (pReady),
    .pTrain   (pTrain),
    .sData    (sData),
    .sValid   (sValid),
    .sReady   (sReady),
    .sSlip    (sSlip),
    .sUnderrun(sUnderrun)
  );

  initial PixelClk = 1'b0;
  always #5 PixelClk = ~PixelClk;

  logic [C-1:0] bq[$];
  int  tests = 0;
  int  fails = 0;
  int  chunks_seen = 0;
  int  slips_applied = 0;
  bit  m_pend = 0;
  bit  m_started = 0;
  bit  m_unf = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [C*P-1:0] pack3(input logic [P-1:0] a, input logic [P-1:0] b,
                                          input logic [P-1:0] d);
    return {d, b, a};
  endfunction

  task automatic model_clear();
    bq.delete();
    m_pend    = 0;
    m_started = 0;
    m_unf     = 0;
  endtask

  // One clock cycle: drive, check handshake against the model, update the scoreboard.
  task automatic cycle(input logic v, input logic [C*P-1:0] d, input logic t,
                       input logic r, input logic s, output logic acc);
    logic           exp_ready;
    logic           exp_valid;
    logic           emit;
    logic           slip;
    logic [C*O-1:0] exp_chunk;
    logic [C-1:0]   col;
    @(negedge PixelClk);
    pValid = v; pData = d; pTrain = t; sReady = r; sSlip = s;
    #1;
    exp_ready = (bq.size() < 2 * O);
    exp_valid = (bq.size() >= O);
    check("p_ready", 64'(pReady), 64'(exp_ready));
    check("s_valid", 64'(sValid), 64'(exp_valid));
    check("s_underrun", 64'(sUnderrun), 64'(m_unf));
    acc  = v && exp_ready;
    emit = exp_valid && r;
    slip = m_pend && (bq.size() >= (emit ? O + 1 : 1));
    if (m_started && r && !exp_valid) m_unf = 1;
    if (emit) begin
      exp_chunk = '0;
      for (int k = 0; k < O; k++) begin
        col = bq.pop_front();
        for (int c = 0; c < C; c++) exp_chunk[c*O + k] = col[c];
      end
      check("s_data", 64'(sData), 64'(exp_chunk));
      chunks_seen++;
    end
    if (slip) begin
      void'(bq.pop_front());
      slips_applied++;
    end
    m_pend = m_pend ? !slip : s;
    if (acc) begin
      for (int k = 0; k < P; k++) begin
        for (int c = 0; c < C; c++) col[c] = t ? kTrain[k] : d[c*P + k];
        bq.push_back(col);
      end
      m_started = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge PixelClk);
    #2;
    aRst = 1'b1; pValid = 1'b0; pTrain = 1'b0; sSlip = 1'b0; sReady = 1'b0;
    #1;
    check("rst_s_valid", 64'(sValid), 64'd0);
    check("rst_s_data", 64'(sData), 64'd0);
    check("rst_s_underrun", 64'(sUnderrun), 64'd0);
    check("rst_p_ready", 64'(pReady), 64'd0);
    @(posedge PixelClk);
    @(negedge PixelClk);
    aRst = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
  endtask

  logic [C*P-1:0] words[12];

  initial begin
    logic acc;
    int   w;
    int   start;
    int   bubbles;
    bit   in_flight;

    aRst = 1'b1; pData = '0; pValid = 1'b0; pTrain = 1'b0; sReady = 1'b0; sSlip = 1'b0;
    do_reset();

    // Single word on lane 0, then idle with sReady high
    cycle(1'b1, pack3(kTrain, '0, '0), 1'b0, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    check("single_c0", 64'(sData[3:0]), 64'(4'b0100));
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    check("single_c1", 64'(sData[3:0]), 64'(4'b0101));
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    check("single_unf", 64'(sUnderrun), 64'd1);

    // Reset mid-stream with bits buffered
    cycle(1'b1, pack3(10'h155, 10'h2aa, 10'h0f0), 1'b0, 1'b0, 1'b1, acc);
    do_reset();

    // Continuous stream of ten words
    w = 0; start = chunks_seen; bubbles = 0;
    for (int cyc = 0; cyc < 200 && (chunks_seen - start) < 25; cyc++) begin
      in_flight = (w > 0);
      cycle(w < 10, pack3(P'(w), P'(w + 16), P'(w + 32)), 1'b0, 1'b1, 1'b0, acc);
      if (acc) w++;
      if (in_flight && !sValid) bubbles++;
    end
    check("stream_chunks", 64'(chunks_seen - start), 64'd25);
    check("stream_bubbles", 64'(bubbles), 64'd0);
    drain();

    // Backpressure: ten stalled cycles mid-stream
    do_reset();
    for (int i = 0; i < 12; i++)
      words[i] = pack3(P'($urandom), P'($urandom), P'($urandom));
    w = 0; start = chunks_seen;
    for (int cyc = 0; cyc < 300 && (w < 12 || bq.size() >= O); cyc++) begin
      cycle(w < 12, (w < 12) ? words[w] : '0, 1'b0, !(cyc >= 8 && cyc < 18), 1'b0, acc);
      if (acc) w++;
      if (cyc == 17) check("bp_ready_low", 64'(pReady), 64'd0);
    end
    check("bp_chunks", 64'(chunks_seen - start), 64'd30);
    drain();

    // Slip: two adjacent pulses coalesce into one dropped bit
    do_reset();
    w = 0; slips_applied = 0;
    for (int cyc = 0; cyc < 200 && (w < 8 || bq.size() >= O); cyc++) begin
      cycle(w < 8, w[0] ? '0 : '1, 1'b0, 1'b1, (cyc == 5 || cyc == 6), acc);
      if (acc) w++;
    end
    check("slip_count", 64'(slips_applied), 64'd1);
    drain();

    // Training words then normal data
    do_reset();
    w = 0;
    for (int cyc = 0; cyc < 200 && (w < 4 || bq.size() >= O); cyc++) begin
      cycle(w < 4, (w < 2) ? '1 : pack3(10'h3c5, 10'h01a, 10'h2e7), w < 2, 1'b1, 1'b0, acc);
      if (acc) w++;
      if (cyc == 1) check("train_c0", 64'(sData), 64'({C{4'b0100}}));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
